// File: rtl/mips_dump_pkg.sv
// Shared types and constants for the MIPS run controller / state dumper.
// Holds the controller state enum, the beat-kind codes and default sizes.
package mips_dump_pkg;

  localparam int unsigned DEF_RUN_CYCLES = 20;
  localparam int unsigned DEF_NREGS      = 32;
  localparam int unsigned DEF_MEM_DEPTH  = 256;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned IDX_W          = 8;
  localparam int unsigned REG_AW         = 5;
  localparam int unsigned MEM_AW         = 8;
  localparam int unsigned PC_W           = 32;

  typedef logic [1:0] dump_kind_t;

  localparam dump_kind_t KIND_REG = 2'd0;
  localparam dump_kind_t KIND_MEM = 2'd1;
  localparam dump_kind_t KIND_PC  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PCD  = 3'd2,
    ST_REGS = 3'd3,
    ST_MEM  = 3'd4,
    ST_DONE = 3'd5
  } dump_state_t;

endpackage

// File: rtl/mips_state_dumper_if.sv
// Valid/ready dump stream carrying one architectural-state word per beat.
//   dump_valid  : beat available (master -> slave)
//   dump_ready  : sink accepts the beat (slave -> master)
//   dump_kind   : 0 register, 1 memory, 2 PC
//   dump_index  : register number / memory word index, 0 for PC
//   dump_data   : beat payload
interface mips_state_dumper_if #(
  parameter int unsigned DATA_W = 32
);
  import mips_dump_pkg::*;

  logic                dump_valid;
  logic                dump_ready;
  dump_kind_t          dump_kind;
  logic [IDX_W-1:0]    dump_index;
  logic [DATA_W-1:0]   dump_data;

  modport master (
    output dump_valid, dump_kind, dump_index, dump_data,
    input  dump_ready
  );

  modport slave (
    input  dump_valid, dump_kind, dump_index, dump_data,
    output dump_ready
  );

endinterface

// File: rtl/dump_run_timer.sv
// Loadable down-counter that times the core RUN phase.
//   clk, reset : clock, synchronous active-high reset
//   load       : load counter with load_val (has priority over en)
//   load_val   : value to load
//   en         : decrement by one while non-zero
//   last_c     : combinational flag, counter currently equals 1
module dump_run_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         last_c
);

  logic [W-1:0] count;

  // Counter register; saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign last_c = (count == W'(1));

endmodule

// File: rtl/mips_state_dumper.sv
// Run controller and architectural-state streamer for the single-cycle MIPS
// core. On start it enables the core for RUN_CYCLES clocks, freezes it, then
// streams all registers and all data-memory words as valid/ready beats.
//
// Optional feature: define MIPS_DUMP_PC_EN to emit a PC beat (kind 2) ahead
// of the register beats. Without it pc_i is unused and kind 2 never appears.
//
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   start       : one-cycle run request, honoured only when idle
//   cpu_run     : core clock-enable, high for exactly RUN_CYCLES cycles
//   reg_addr    : register-file read address (same-cycle reg_rdata)
//   reg_rdata   : register-file read data
//   mem_addr    : data-memory read address (same-cycle mem_rdata)
//   mem_rdata   : data-memory read data
//   pc_i        : core PC (PC beat only)
//   busy        : high whenever not idle
//   done        : one-cycle pulse after the last beat is accepted
//   dump        : valid/ready beat stream (master side)
module mips_state_dumper
  import mips_dump_pkg::*;
#(
  parameter int unsigned RUN_CYCLES = DEF_RUN_CYCLES,
  parameter int unsigned NREGS      = DEF_NREGS,
  parameter int unsigned MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int unsigned DATA_W     = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  cpu_run,
  output logic [REG_AW-1:0]     reg_addr,
  input  logic [DATA_W-1:0]     reg_rdata,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic [PC_W-1:0]       pc_i,
  output logic                  busy,
  output logic                  done,
  mips_state_dumper_if.master   dump
);

  localparam int unsigned CNT_W = (RUN_CYCLES < 2) ? 1 : $clog2(RUN_CYCLES + 1);
  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(NREGS - 1);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_DEPTH - 1);

`ifdef MIPS_DUMP_PC_EN
  localparam dump_state_t FIRST_DUMP = ST_PCD;
`else
  localparam dump_state_t FIRST_DUMP = ST_REGS;
  logic unused_pc;
  assign unused_pc = ^pc_i;
`endif

  dump_state_t      state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             timer_load;
  logic             timer_last_c;
  logic             hs_c;

  // RUN-phase length counter.
  dump_run_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (CNT_W'(RUN_CYCLES)),
    .en       (state == ST_RUN),
    .last_c   (timer_last_c)
  );

  // Handshake; ready alone has no effect.
  assign hs_c = dump.dump_valid && dump.dump_ready;

  // State and walk-index registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic; the index only moves on a handshake so the beat stays stable.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    timer_load = 1'b0;
    case (state)
      ST_IDLE: begin
        idx_nxt = '0;
        if (start) begin
          timer_load = 1'b1;
          state_nxt  = (RUN_CYCLES == 0) ? FIRST_DUMP : ST_RUN;
        end
      end
      ST_RUN: begin
        if (timer_last_c) begin
          state_nxt = FIRST_DUMP;
        end
      end
`ifdef MIPS_DUMP_PC_EN
      ST_PCD: begin
        if (hs_c) begin
          state_nxt = ST_REGS;
        end
      end
`endif
      ST_REGS: begin
        if (hs_c) begin
          if (idx == REG_LAST) begin
            state_nxt = ST_MEM;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      ST_MEM: begin
        if (hs_c) begin
          if (idx == MEM_LAST) begin
            state_nxt = ST_DONE;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Output decode from the registered state and index.
  always_comb begin
    cpu_run         = 1'b0;
    busy            = (state != ST_IDLE);
    done            = 1'b0;
    reg_addr        = '0;
    mem_addr        = '0;
    dump.dump_valid = 1'b0;
    dump.dump_kind  = KIND_REG;
    dump.dump_index = '0;
    dump.dump_data  = '0;
    case (state)
      ST_RUN: begin
        cpu_run = 1'b1;
      end
`ifdef MIPS_DUMP_PC_EN
      ST_PCD: begin
        dump.dump_valid = 1'b1;
        dump.dump_kind  = KIND_PC;
        dump.dump_data  = DATA_W'(pc_i);
      end
`endif
      ST_REGS: begin
        reg_addr        = idx[REG_AW-1:0];
        dump.dump_valid = 1'b1;
        dump.dump_kind  = KIND_REG;
        dump.dump_index = idx;
        dump.dump_data  = reg_rdata;
      end
      ST_MEM: begin
        mem_addr        = idx[MEM_AW-1:0];
        dump.dump_valid = 1'b1;
        dump.dump_kind  = KIND_MEM;
        dump.dump_index = idx;
        dump.dump_data  = mem_rdata;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_state_dumper.sv
// Randomized self-checking bench for mips_state_dumper. A small core model
// (register file, memory, PC that advance only while cpu_run is high) feeds
// the read ports; the expected beat list is rebuilt from the stored state and
// the number of run cycles each start should grant.
module tb_mips_state_dumper;
  import mips_dump_pkg::*;

  localparam int unsigned RUN_N = 20;
`ifdef MIPS_DUMP_PC_EN
  localparam int unsigned PC_BEATS = 1;
`else
  localparam int unsigned PC_BEATS = 0;
`endif

  logic clk = 1'b0;
  logic reset, start, start0;
  always #5 clk = ~clk;

  // Core model state
  logic [31:0] rf  [32];
  logic [31:0] mem [256];
  logic [31:0] pc_base;
  logic [31:0] core_ticks = '0;

  // Main DUT signals
  logic        cpu_run, busy, done;
  logic [4:0]  reg_addr;
  logic [7:0]  mem_addr;
  logic [31:0] reg_rdata, mem_rdata, pc_i;
  mips_state_dumper_if #(.DATA_W(32)) dump_if ();

  // Zero-run-length DUT signals
  logic        cpu_run0, busy0, done0;
  logic [4:0]  reg_addr0;
  logic [7:0]  mem_addr0;
  logic [31:0] reg_rdata0, mem_rdata0;
  mips_state_dumper_if #(.DATA_W(32)) dump0_if ();

  assign reg_rdata  = rf[reg_addr]  + ((reg_addr  == 5'd2) ? core_ticks : 32'd0);
  assign reg_rdata0 = rf[reg_addr0] + ((reg_addr0 == 5'd2) ? core_ticks : 32'd0);
  assign mem_rdata  = mem[mem_addr];
  assign mem_rdata0 = mem[mem_addr0];
  assign pc_i       = pc_base + (core_ticks << 2);

  mips_state_dumper #(
    .RUN_CYCLES (RUN_N), .NREGS (32), .MEM_DEPTH (256), .DATA_W (32)
  ) u_dut (
    .clk (clk), .reset (reset), .start (start), .cpu_run (cpu_run),
    .reg_addr (reg_addr), .reg_rdata (reg_rdata), .mem_addr (mem_addr),
    .mem_rdata (mem_rdata), .pc_i (pc_i), .busy (busy), .done (done),
    .dump (dump_if)
  );

  mips_state_dumper #(
    .RUN_CYCLES (0), .NREGS (32), .MEM_DEPTH (256), .DATA_W (32)
  ) u_dut0 (
    .clk (clk), .reset (reset), .start (start0), .cpu_run (cpu_run0),
    .reg_addr (reg_addr0), .reg_rdata (reg_rdata0), .mem_addr (mem_addr0),
    .mem_rdata (mem_rdata0), .pc_i (pc_i), .busy (busy0), .done (done0),
    .dump (dump0_if)
  );

  // The core only advances while enabled.
  int run_cnt = 0, run0_cnt = 0, done_cnt = 0;
  always @(posedge clk) begin
    if (cpu_run) begin
      core_ticks <= core_ticks + 32'd1;
      run_cnt    <= run_cnt + 1;
    end
    if (cpu_run0) run0_cnt <= run0_cnt + 1;
    if (done)     done_cnt <= done_cnt + 1;
  end

  int n_chk = 0, n_fail = 0;
  int exp_ticks = 0;
  logic [41:0] exp_q[$];   // {kind, index, data}

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference beat list: optional PC, then every register, then every word.
  task automatic build_expected();
    exp_q.delete();
`ifdef MIPS_DUMP_PC_EN
    exp_q.push_back({2'd2, 8'd0, pc_base + 32'(exp_ticks * 4)});
`endif
    for (int r = 0; r < 32; r++)
      exp_q.push_back({2'd0, 8'(r), rf[r] + ((r == 2) ? 32'(exp_ticks) : 32'd0)});
    for (int m = 0; m < 256; m++)
      exp_q.push_back({2'd1, 8'(m), mem[m]});
  endtask

  task automatic randomize_state();
    for (int r = 0; r < 32; r++) rf[r] = $urandom();
    for (int m = 0; m < 256; m++) mem[m] = $urandom();
    rf[0]  = 32'd0;
    rf[1]  = 32'd5;
    mem[4] = 32'h1234;
  endtask

  // One start-to-done run; optionally random ready, a stray start at a given
  // beat, or a reset once memory index abort_idx is presented.
  task automatic do_run(input bit rand_ready, input int start_beat, input int abort_idx);
    int lat, k, cyc, runs0, dones0, n_exp;
    logic [42:0] beat, held;
    bit holding, aborted, rdy, sent;
    runs0  = run_cnt;
    dones0 = done_cnt;
    exp_ticks += RUN_N;
    build_expected();
    n_exp = exp_q.size();
    chk("expected_beat_count", 64'(n_exp), 64'(288 + PC_BEATS));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 1;
    while (!dump_if.dump_valid && lat <= int'(RUN_N) + 50) begin
      @(negedge clk);
      lat++;
    end
    chk("first_valid_cycle", 64'(lat), 64'(RUN_N + 1));
    chk("cpu_run_cycles", 64'(run_cnt - runs0), 64'(RUN_N));
    k = 0; cyc = 0; holding = 1'b0; aborted = 1'b0; sent = 1'b0;
    while (k < n_exp && cyc < 8 * n_exp && !aborted) begin
      start = 1'b0;
      beat = {dump_if.dump_valid, dump_if.dump_kind, dump_if.dump_index, dump_if.dump_data};
      if (holding) chk("stall_hold", 64'(beat), 64'(held));
      if (abort_idx >= 0 && dump_if.dump_kind == KIND_MEM &&
          int'(dump_if.dump_index) == abort_idx) begin
        reset = 1'b1;
        dump_if.dump_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_mid_dump", 64'({cpu_run, busy, dump_if.dump_valid}), 64'd0);
        aborted = 1'b1;
      end else begin
        if (k == start_beat && !sent) begin
          start = 1'b1;
          sent  = 1'b1;
        end
        rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        dump_if.dump_ready = rdy;
        if (rdy) begin
          chk($sformatf("beat%0d", k), 64'(beat), 64'({1'b1, exp_q[k]}));
          k++;
          holding = 1'b0;
        end else begin
          held    = beat;
          holding = 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      chk("beats_accepted", 64'(k), 64'(n_exp));
      if (!rand_ready) chk("dump_cycles", 64'(cyc), 64'(n_exp));
      chk("done_after_last", 64'({done, dump_if.dump_valid}), 64'(2'b10));
      @(negedge clk);
      chk("done_one_cycle", 64'({done, busy}), 64'd0);
      repeat (8) @(negedge clk);
      chk("idle_after_done", 64'({busy, cpu_run}), 64'd0);
      chk("done_pulses", 64'(done_cnt - dones0), 64'd1);
      chk("no_extra_run", 64'(run_cnt - runs0), 64'(RUN_N));
    end
  endtask

  initial begin
    int n0, cyc0;
    reset = 1'b1; start = 1'b0; start0 = 1'b0;
    dump_if.dump_ready = 1'b0;
    dump0_if.dump_ready = 1'b0;
    randomize_state();
    pc_base = $urandom() & 32'hFFFF_FFFC;

    // Reset held for three cycles, then idle with start low.
    repeat (3) @(negedge clk);
    chk("in_reset", 64'({busy, cpu_run, dump_if.dump_valid, done}), 64'd0);
    reset = 1'b0;
    dump_if.dump_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_idle", 64'({busy, cpu_run, dump_if.dump_valid, done}), 64'd0);
    end
    chk("reset_payload", 64'({dump_if.dump_kind, dump_if.dump_index, dump_if.dump_data,
                              reg_addr, mem_addr}), 64'd0);
    chk("reset_idle0", 64'({busy0, cpu_run0, dump0_if.dump_valid}), 64'd0);

    // Basic run, ready held high.
    do_run(1'b0, -1, -1);

    // Backpressure with a stray start during the register walk.
    randomize_state();
    do_run(1'b1, 10 + int'(PC_BEATS), -1);

    // Reset during the memory walk at index 100, then a clean restart.
    randomize_state();
    do_run(1'b0, -1, 100);
    chk("idle_after_reset", 64'({busy, dump_if.dump_valid}), 64'd0);
    do_run(1'b0, -1, -1);

    // Zero run length: first beat the cycle after start, core never enabled.
    build_expected();
    dump0_if.dump_ready = 1'b1;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    chk("zero_run_first_beat",
        64'({dump0_if.dump_valid, dump0_if.dump_kind, dump0_if.dump_index, dump0_if.dump_data}),
        64'({1'b1, exp_q[0]}));
    n0 = 0; cyc0 = 0;
    while (!done0 && cyc0 < 1000) begin
      if (dump0_if.dump_valid) n0++;
      @(negedge clk);
      cyc0++;
    end
    chk("zero_run_beats", 64'(n0), 64'(288 + PC_BEATS));
    chk("zero_run_done", 64'(done0), 64'd1);
    chk("zero_run_no_cpu", 64'(run0_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/mips_state_dumper.md
# mips_state_dumper

Run controller and architectural-state streamer for the single-cycle MIPS core. On `start` it lets the core execute a fixed number of clock cycles, freezes it, then walks all 32 general registers and every data-memory word and emits each as one beat on a valid/ready stream. It is the hardware counterpart of bench-side register and memory inspection, so that end-of-run state can leave the chip over a UART or trace link.

## Interface
- `RUN_CYCLES`, 20: core cycles executed per run; 0 is legal.
- `NREGS`, 32: register-file entries dumped.
- `MEM_DEPTH`, 256: data-memory words dumped.
- `DATA_W`, 32: register and memory word width.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `cpu_run` out 1: clock-enable to the core; the core holds all state while low.
- `reg_addr` out 5: register-file read address.
- `reg_rdata` in DATA_W: combinational (same-cycle) register read data.
- `mem_addr` out 8: data-memory read address.
- `mem_rdata` in DATA_W: combinational (same-cycle) memory read data.
- `pc_i` in 32: core PC; used only with `DUMP_PC_EN`.
- `dump_valid` out 1: beat available.
- `dump_ready` in 1: sink accepts the beat.
- `dump_kind` out 2: 0 = register, 1 = memory, 2 = PC.
- `dump_index` out 8: register number or memory word index; 0 for PC.
- `dump_data` out DATA_W: beat payload.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last beat is accepted.

## Operation
- States: IDLE, RUN, PCD (only with `DUMP_PC_EN`), REGS, MEM, DONE.
- IDLE:
  - Outputs idle.
  - On `start`, go to RUN and load the cycle counter with `RUN_CYCLES`.
  - If `RUN_CYCLES` is 0, go directly to the first dump state instead.
- RUN:
  - `cpu_run` = 1.
  - The counter decrements each cycle; at 1 it moves to the first dump state.
  - `cpu_run` is therefore high for exactly `RUN_CYCLES` cycles.
- PCD: one beat with `dump_kind`=2 and `dump_data`=`pc_i`, then REGS.
- REGS:
  - The index counter starts at 0 and drives `reg_addr`.
  - `dump_data`=`reg_rdata`, `dump_kind`=0.
  - On a handshake (`dump_valid` and `dump_ready`) the index increments.
  - After index `NREGS-1` is accepted, go to MEM with the index cleared to 0.
- MEM:
  - Same walk over `mem_addr` 0..`MEM_DEPTH-1`, with `dump_kind`=1.
  - After the last beat is accepted, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `dump_valid` is high in every dump state.
- Payload, kind and index are stable while `dump_valid` is high and `dump_ready` is low. This holds because the core is frozen and the index changes only on a handshake.
- The index counter is 8 bits wide; `reg_addr` is its low 5 bits. No wrap occurs, because state changes at the terminal index.
- `start` outside IDLE is ignored and is not queued.

## Timing
- Reset values:
  - state = IDLE;
  - `cpu_run`, `dump_valid`, `busy`, `done` = 0;
  - `dump_kind`, `dump_index`, `dump_data`, `reg_addr`, `mem_addr` = 0.
- Latency: with `start` at cycle 0, `cpu_run` is high in cycles 1..`RUN_CYCLES`, and the first dump beat is valid in cycle `RUN_CYCLES`+1.
- Throughput is one beat per cycle with `dump_ready` held high. A full dump takes `NREGS`+`MEM_DEPTH` cycles (+1 with PC).
- `done` occurs the cycle after the final handshake.
- `dump_ready` may be high while `dump_valid` is low; this has no effect.
- Reset mid-operation: returns to IDLE on the next edge and drops `cpu_run` and `dump_valid` immediately. Core state is not touched, because the core has its own reset.

## Configuration
- `MIPS_DUMP_PC_EN`, when defined:
  - the PCD state and `pc_i` are used;
  - the PC beat precedes the register beats;
  - the full dump is 289 beats with default parameters.
- When undefined:
  - no PCD state, and `pc_i` is unused;
  - the dump is 288 beats;
  - `dump_kind` never equals 2.

## Structure
- Package `mips_dump_pkg` holds:
  - the state enum;
  - the `KIND_REG`/`KIND_MEM`/`KIND_PC` constants;
  - default widths.
- Sub-module `dump_run_timer`: a loadable down-counter with a terminal flag, used for the RUN phase.

## Test plan
- Reset check: reset held 3 cycles, then released with `start`=0 -> `busy`=0, `cpu_run`=0, `dump_valid`=0 indefinitely.
- Basic run: `start` with defaults and `dump_ready`=1; R1 is preloaded to 5 and Mem[4] to 0x1234.
  - `cpu_run` is high for exactly 20 cycles.
  - 288 beats follow, with R1 emitted as kind 0, index 1, data 5, and Mem[4] as kind 1, index 4, data 0x1234.
  - `done` pulses once.
- Backpressure: `dump_ready` toggles pseudo-randomly -> every beat is held stable while stalled, with no beat skipped or duplicated (indices strictly 0..31 then 0..255).
- Ignored start and zero run length: `start` is pulsed during REGS -> ignored. With `RUN_CYCLES`=0 -> `cpu_run` is never high and the first beat is valid the cycle after `start`.
- Reset mid-dump: `reset` during MEM at index 100 -> the next cycle is IDLE with `dump_valid`=0. A new `start` restarts from RUN and register index 0.
- `MIPS_DUMP_PC_EN` defined: after 20 cycles of `cpu_run` -> the first beat is kind 2 with data equal to `pc_i`, followed by 288 further beats.
